// File: rtl/btn_pkg.sv
// Shared types and default timing for the button conditioner.
// Defaults assume a 25 MHz system clock.
package btn_pkg;

   typedef enum logic [1:0] {
      RPT_IDLE   = 2'd0,
      RPT_DELAY  = 2'd1,
      RPT_REPEAT = 2'd2
   } rpt_state_e;

   localparam int CLK_HZ = 25_000_000;

   localparam int DEF_SYNC_STAGES     = 2;
   // 10 ms settle, 500 ms before auto-repeat, then 10 repeats per second
   localparam int DEF_DEBOUNCE_CYCLES = CLK_HZ / 100;
   localparam int DEF_REPEAT_DELAY    = CLK_HZ / 2;
   localparam int DEF_REPEAT_RATE     = CLK_HZ / 10;

   function automatic int max_int(input int a, input int b);
      return (a > b) ? a : b;
   endfunction

endpackage

// File: rtl/btn_channel.sv
// One button channel: synchroniser, debounce filter and auto-repeat FSM.
// All pulse outputs are registered and last exactly one cycle.
module btn_channel
   import btn_pkg::*;
#(
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter bit ACTIVE_LOW      = 1'b0
) (
   input  logic clk,
   input  logic rst,
   input  logic raw,
   input  logic repeat_en,
   output logic level,
   output logic press_pulse,
   output logic release_pulse,
   output logic event_pulse
);

   localparam int DW = $clog2(DEBOUNCE_CYCLES + 1);
   localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_RATE) + 1);

   localparam logic [DW-1:0] DB_LAST   = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [RW-1:0] DLY_LAST  = RW'(REPEAT_DELAY - 1);
   localparam logic [RW-1:0] RATE_LAST = RW'(REPEAT_RATE - 1);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   synced;
   logic                   mismatch;
   logic                   accept;
   logic                   press_acc;
   logic                   release_acc;
   logic [DW-1:0]          db_cnt;

   rpt_state_e             state;
   rpt_state_e             state_nx;
   logic [RW-1:0]          rpt_cnt;
   logic [RW-1:0]          rpt_cnt_nx;
   logic                   tick;

   assign synced      = sync_q[SYNC_STAGES-1];
   assign mismatch    = synced ^ level;
   assign accept      = mismatch && (db_cnt == DB_LAST);
   assign press_acc   = accept && synced;
   assign release_acc = accept && !synced;

   always_ff @(posedge clk) begin
      if (rst) begin
         sync_q <= '0;
      end else begin
         sync_q <= {sync_q[SYNC_STAGES-2:0], raw ^ ACTIVE_LOW};
      end
   end

   // Counter only runs while the synchronised input disagrees with level
   always_ff @(posedge clk) begin
      if (rst) begin
         db_cnt        <= '0;
         level         <= 1'b0;
         press_pulse   <= 1'b0;
         release_pulse <= 1'b0;
      end else begin
         press_pulse   <= press_acc;
         release_pulse <= release_acc;
         if (!mismatch || accept) begin
            db_cnt <= '0;
         end else begin
            db_cnt <= db_cnt + DW'(1);
         end
         if (accept) begin
            level <= ~level;
         end
      end
   end

   // Release or a dropped enable overrides every state and suppresses the tick
   always_comb begin
      state_nx   = state;
      rpt_cnt_nx = rpt_cnt;
      tick       = 1'b0;
      if (release_acc || !repeat_en) begin
         state_nx   = RPT_IDLE;
         rpt_cnt_nx = '0;
      end else begin
         unique case (state)
            RPT_IDLE: begin
               if (press_acc) begin
                  state_nx   = RPT_DELAY;
                  rpt_cnt_nx = '0;
               end
            end
            RPT_DELAY: begin
               if (rpt_cnt == DLY_LAST) begin
                  tick       = 1'b1;
                  state_nx   = RPT_REPEAT;
                  rpt_cnt_nx = '0;
               end else begin
                  rpt_cnt_nx = rpt_cnt + RW'(1);
               end
            end
            RPT_REPEAT: begin
               if (rpt_cnt == RATE_LAST) begin
                  tick       = 1'b1;
                  rpt_cnt_nx = '0;
               end else begin
                  rpt_cnt_nx = rpt_cnt + RW'(1);
               end
            end
            default: begin
               state_nx   = RPT_IDLE;
               rpt_cnt_nx = '0;
            end
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= RPT_IDLE;
         rpt_cnt     <= '0;
         event_pulse <= 1'b0;
      end else begin
         state       <= state_nx;
         rpt_cnt     <= rpt_cnt_nx;
         event_pulse <= press_acc || tick;
      end
   end

endmodule

// File: rtl/btn_conditioner.sv
// Multi-channel button conditioner: N_BTN independent copies of
// btn_channel sharing only clock and reset.
module btn_conditioner
   import btn_pkg::*;
#(
   parameter int N_BTN           = 3,
   parameter int SYNC_STAGES     = DEF_SYNC_STAGES,
   parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES,
   parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
   parameter int REPEAT_RATE     = DEF_REPEAT_RATE,
   parameter int ACTIVE_LOW      = 0
) (
   input  logic             clk,
   input  logic             rst,
   input  logic [N_BTN-1:0] btn_raw,
   input  logic [N_BTN-1:0] repeat_en,
   output logic [N_BTN-1:0] btn_level,
   output logic [N_BTN-1:0] btn_press,
   output logic [N_BTN-1:0] btn_release,
   output logic [N_BTN-1:0] btn_event
);

   for (genvar i = 0; i < N_BTN; i++) begin : g_ch
      btn_channel #(
         .SYNC_STAGES     (SYNC_STAGES),
         .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
         .REPEAT_DELAY    (REPEAT_DELAY),
         .REPEAT_RATE     (REPEAT_RATE),
         .ACTIVE_LOW      (ACTIVE_LOW != 0)
      ) u_ch (
         .clk           (clk),
         .rst           (rst),
         .raw           (btn_raw[i]),
         .repeat_en     (repeat_en[i]),
         .level         (btn_level[i]),
         .press_pulse   (btn_press[i]),
         .release_pulse (btn_release[i]),
         .event_pulse   (btn_event[i])
      );
   end

endmodule

// File: tb/tb_btn_conditioner.sv
// Directed bench for btn_conditioner with short timing parameters.
// A second instance covers the active-low input option.
module tb_btn_conditioner;

   logic       clk = 1'b0;
   logic       rst, rst_al;
   logic [2:0] raw, ren, raw_al, ren_al;
   logic [2:0] lvl, prs, rls, evt;
   logic [2:0] lvl_al, prs_al, rls_al, evt_al;

   int tests_run    = 0;
   int tests_failed = 0;

   always #5 clk = ~clk;

   btn_conditioner #(
      .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(8), .REPEAT_RATE(3), .ACTIVE_LOW(0)
   ) dut (
      .clk(clk), .rst(rst), .btn_raw(raw), .repeat_en(ren),
      .btn_level(lvl), .btn_press(prs),
      .btn_release(rls), .btn_event(evt)
   );

   btn_conditioner #(
      .N_BTN(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4),
      .REPEAT_DELAY(8), .REPEAT_RATE(3), .ACTIVE_LOW(1)
   ) dut_al (
      .clk(clk), .rst(rst_al), .btn_raw(raw_al), .repeat_en(ren_al),
      .btn_level(lvl_al), .btn_press(prs_al),
      .btn_release(rls_al), .btn_event(evt_al)
   );

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic test_reset();
      rst = 1'b1; raw = '0; ren = '0;
      rst_al = 1'b1; raw_al = 3'b111; ren_al = '0;
      tick(); tick();
      tests_run++;
      if ({lvl, prs, rls, evt} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_main got %h exp 000", {lvl, prs, rls, evt});
      end
      tests_run++;
      if ({lvl_al, prs_al, rls_al, evt_al} !== 12'h000) begin
         tests_failed++;
         $display("FAIL reset_al got %h exp 000",
                  {lvl_al, prs_al, rls_al, evt_al});
      end
      rst = 1'b0; rst_al = 1'b0;
      tick();
   endtask

   task automatic test_press();
      logic el, ep;
      raw[0] = 1'b1;
      for (int k = 1; k <= 8; k++) begin
         tick();
         el = (k >= 6); ep = (k == 6);
         tests_run++;
         if (lvl[0] !== el || prs[0] !== ep || evt[0] !== ep || rls[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL press_ch0 k=%0d got l%b p%b e%b r%b exp l%b p%b e%b r0",
                     k, lvl[0], prs[0], evt[0], rls[0], el, ep, ep);
         end
      end
      raw[0] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         el = (k < 6); ep = (k == 6);
         tests_run++;
         if (lvl[0] !== el || rls[0] !== ep || prs[0] !== 1'b0 || evt[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL release_ch0 k=%0d got l%b r%b p%b e%b exp l%b r%b p0 e0",
                     k, lvl[0], rls[0], prs[0], evt[0], el, ep);
         end
      end
   endtask

   task automatic test_glitch();
      raw[1] = 1'b1;
      for (int k = 1; k <= 14; k++) begin
         if (k == 4) raw[1] = 1'b0;
         tick();
         tests_run++;
         if ({lvl[1], prs[1], rls[1], evt[1]} !== 4'b0000) begin
            tests_failed++;
            $display("FAIL glitch_ch1 k=%0d got %b exp 0000",
                     k, {lvl[1], prs[1], rls[1], evt[1]});
         end
      end
   endtask

   task automatic test_repeat();
      logic el, ee, er;
      ren[2] = 1'b1; raw[2] = 1'b1;
      for (int k = 1; k <= 6; k++) begin
         tick();
         ee = (k == 6);
         tests_run++;
         if (prs[2] !== ee || evt[2] !== ee) begin
            tests_failed++;
            $display("FAIL repeat_press k=%0d got p%b e%b exp p%b e%b",
                     k, prs[2], evt[2], ee, ee);
         end
      end
      // k counts edges after the press cycle P; raw falls before P+31
      for (int k = 1; k <= 45; k++) begin
         if (k == 31) raw[2] = 1'b0;
         tick();
         el = (k < 36);
         er = (k == 36);
         ee = (k >= 8) && (k < 36) && ((k - 8) % 3 == 0);
         tests_run++;
         if (lvl[2] !== el || evt[2] !== ee || rls[2] !== er || prs[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL repeat_ticks k=%0d got l%b e%b r%b p%b exp l%b e%b r%b p0",
                     k, lvl[2], evt[2], rls[2], prs[2], el, ee, er);
         end
      end
      ren[2] = 1'b0;
   endtask

   task automatic test_repeat_drop();
      logic ee;
      ren[2] = 1'b1; raw[2] = 1'b1;
      for (int k = 1; k <= 6; k++) tick();
      tests_run++;
      if (prs[2] !== 1'b1 || evt[2] !== 1'b1) begin
         tests_failed++;
         $display("FAIL drop_press got p%b e%b exp p1 e1", prs[2], evt[2]);
      end
      // enable drops at P+9, comes back at P+12 while still held
      for (int k = 1; k <= 24; k++) begin
         if (k == 9) ren[2] = 1'b0;
         if (k == 12) ren[2] = 1'b1;
         tick();
         ee = (k == 8);
         tests_run++;
         if (evt[2] !== ee) begin
            tests_failed++;
            $display("FAIL drop_event k=%0d got %b exp %b", k, evt[2], ee);
         end
      end
      raw[2] = 1'b0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         tests_run++;
         if (rls[2] !== (k == 6) || evt[2] !== 1'b0) begin
            tests_failed++;
            $display("FAIL drop_release k=%0d got r%b e%b exp r%b e0",
                     k, rls[2], evt[2], (k == 6));
         end
      end
      ren[2] = 1'b0;
   endtask

   task automatic test_active_low_reset();
      logic el, ep;
      for (int k = 1; k <= 10; k++) begin
         tick();
         tests_run++;
         if ({lvl_al, prs_al, evt_al} !== 9'h000) begin
            tests_failed++;
            $display("FAIL al_idle k=%0d got %h exp 000", k, {lvl_al, prs_al, evt_al});
         end
      end
      ren_al[0] = 1'b1; raw_al[0] = 1'b0;
      // press lands at k=6, reset edge at k=11 (P+5) with button still held
      for (int k = 1; k <= 11; k++) begin
         if (k == 11) rst_al = 1'b1;
         tick();
         el = (k >= 6) && (k < 11); ep = (k == 6);
         tests_run++;
         if (lvl_al[0] !== el || prs_al[0] !== ep || evt_al[0] !== ep || rls_al[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL al_press k=%0d got l%b p%b e%b r%b exp l%b p%b e%b r0",
                     k, lvl_al[0], prs_al[0], evt_al[0], rls_al[0], el, ep, ep);
         end
      end
      rst_al = 1'b0;
      for (int k = 1; k <= 10; k++) begin
         tick();
         el = (k >= 6); ep = (k == 6);
         tests_run++;
         if (lvl_al[0] !== el || prs_al[0] !== ep || evt_al[0] !== ep || rls_al[0] !== 1'b0) begin
            tests_failed++;
            $display("FAIL al_after_rst k=%0d got l%b p%b e%b r%b exp l%b p%b e%b r0",
                     k, lvl_al[0], prs_al[0], evt_al[0], rls_al[0], el, ep, ep);
         end
      end
      raw_al[0] = 1'b1; ren_al = '0;
      for (int k = 1; k <= 8; k++) tick();
   endtask

   task automatic test_simultaneous();
      logic [2:0] ep, el;
      raw = 3'b111; ren = '0;
      for (int k = 1; k <= 8; k++) begin
         tick();
         ep = (k == 6) ? 3'b111 : 3'b000;
         el = (k >= 6) ? 3'b111 : 3'b000;
         tests_run++;
         if (prs !== ep || evt !== ep || lvl !== el) begin
            tests_failed++;
            $display("FAIL simul_press k=%0d got p%b e%b l%b exp p%b e%b l%b",
                     k, prs, evt, lvl, ep, ep, el);
         end
      end
      raw = 3'b000;
      for (int k = 1; k <= 8; k++) begin
         tick();
         ep = (k == 6) ? 3'b111 : 3'b000;
         tests_run++;
         if (rls !== ep || prs !== 3'b000) begin
            tests_failed++;
            $display("FAIL simul_release k=%0d got r%b p%b exp r%b p000",
                     k, rls, prs, ep);
         end
      end
   endtask

   initial begin
      test_reset();
      test_press();
      test_glitch();
      test_repeat();
      test_repeat_drop();
      test_active_low_reset();
      test_simultaneous();
      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
